// File: rtl/xbar_config_loader_if.sv
// Config stream, status and active-image bundle shared by the tile config port (master)
// and the crossbar config loader (slave).
interface xbar_config_loader_if #(
  parameter int unsigned NUM_OUTS = 54,
  parameter int unsigned SEL_W    = 6,
  parameter int unsigned WORD_W   = 8
);
  localparam int unsigned CFG_W = NUM_OUTS * SEL_W;

  logic              io_cfg_start;
  logic              io_cfg_valid;
  logic              io_cfg_ready;
  logic [WORD_W-1:0] io_cfg_data;
  logic              io_busy;
  logic              io_done;
  logic              io_error;
  logic              io_cfg_loaded;
  logic [CFG_W-1:0]  io_mux_configs;

  modport master (
    output io_cfg_start, io_cfg_valid, io_cfg_data,
    input  io_cfg_ready, io_busy, io_done, io_error, io_cfg_loaded, io_mux_configs
  );

  modport slave (
    input  io_cfg_start, io_cfg_valid, io_cfg_data,
    output io_cfg_ready, io_busy, io_done, io_error, io_cfg_loaded, io_mux_configs
  );
endinterface

// File: rtl/xbar_config_loader.sv
// Crossbar mux-config writer: assembles a shadow image from a word stream, range-checks every
// selector, and commits the image atomically so the xbar never sees a partial or illegal config.
module xbar_config_loader #(
  parameter int unsigned NUM_INS  = 39,
  parameter int unsigned NUM_OUTS = 54,
  parameter int unsigned SEL_W    = 6,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  xbar_config_loader_if.slave  bus
);
  localparam int unsigned CFG_W     = NUM_OUTS * SEL_W;
  localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int unsigned SHADOW_W  = NUM_WORDS * WORD_W;
  localparam int unsigned SH_IDX_W  = $clog2(SHADOW_W);
  localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int unsigned SCNT_W    = $clog2(NUM_OUTS);

  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(NUM_WORDS - 1);
  localparam logic [WCNT_W-1:0] WORDS_DONE = WCNT_W'(NUM_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [SCNT_W-1:0] LAST_SEL   = SCNT_W'(NUM_OUTS - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE   = SCNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    return (32'(sel) >= 32'(NUM_INS));
  endfunction

  state_e              state_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [SCNT_W-1:0]   sel_cnt_q;
  logic [SHADOW_W-1:0] shadow_q;
  logic [CFG_W-1:0]    mux_q;
  logic                bad_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                loaded_q;

  logic                xfer_s;
  logic [SH_IDX_W-1:0] word_base_s;
  logic [SH_IDX_W-1:0] sel_base_s;
  logic [SEL_W-1:0]    cur_sel_s;
  logic [SHADOW_W-1:0] shadow_d;

  // Transfer qualification, shadow merge of the incoming word and current selector fetch
  always_comb begin
    xfer_s      = bus.io_cfg_valid & ready_q;
    word_base_s = SH_IDX_W'(word_cnt_q) * SH_IDX_W'(WORD_W);
    sel_base_s  = SH_IDX_W'(sel_cnt_q) * SH_IDX_W'(SEL_W);
    cur_sel_s   = shadow_q[sel_base_s +: SEL_W];
    shadow_d    = shadow_q;
    if (xfer_s) begin
      shadow_d[word_base_s +: WORD_W] = bus.io_cfg_data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Loader FSM with all status outputs and the active image held in registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      sel_cnt_q  <= '0;
      shadow_q   <= '0;
      mux_q      <= '0;
      bad_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        ST_LOAD: begin
          // One idle cycle after the final word, with ready already low, before checking starts
          if (word_cnt_q == WORDS_DONE) begin
            state_q   <= ST_CHECK;
            sel_cnt_q <= '0;
          end else if (xfer_s) begin
            shadow_q   <= shadow_d;
            word_cnt_q <= word_cnt_q + WCNT_ONE;
            if (word_cnt_q == LAST_WORD) begin
              ready_q <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (sel_illegal(cur_sel_s)) begin
            bad_q <= 1'b1;
          end
          if (sel_cnt_q == LAST_SEL) begin
            state_q <= ST_COMMIT;
          end else begin
            sel_cnt_q <= sel_cnt_q + SCNT_ONE;
          end
        end
        ST_COMMIT: begin
          if (!bad_q) begin
            mux_q    <= shadow_q[CFG_W-1:0];
            loaded_q <= 1'b1;
          end else begin
            error_q <= 1'b1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      // Start overrides everything above; a commit in flight still lands and keeps its verdict
      if (bus.io_cfg_start) begin
        state_q    <= ST_LOAD;
        word_cnt_q <= '0;
        shadow_q   <= '0;
        bad_q      <= 1'b0;
        ready_q    <= 1'b1;
        busy_q     <= 1'b1;
        if (state_q != ST_COMMIT) begin
          error_q <= 1'b0;
        end
      end
    end
  end

  assign bus.io_cfg_ready   = ready_q;
  assign bus.io_busy        = busy_q;
  assign bus.io_done        = done_q;
  assign bus.io_error       = error_q;
  assign bus.io_cfg_loaded  = loaded_q;
  assign bus.io_mux_configs = mux_q;

endmodule

// File: tb/tb_xbar_config_loader.sv
// Directed/randomized bench for xbar_config_loader: images are built from selector lists and
// the expected active image follows the commit-only-if-all-legal rule.
module tb_xbar_config_loader;
  localparam int NUM_INS  = 39;
  localparam int NUM_OUTS = 54;
  localparam int SEL_W    = 6;
  localparam int WORD_W   = 8;
  localparam int CFG_W    = NUM_OUTS * SEL_W;
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;

  typedef logic [CFG_W-1:0] img_t;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  img_t exp_img;
  bit   exp_loaded;

  xbar_config_loader_if cfg ();

  xbar_config_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (cfg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input img_t obs, input img_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic img_t identity_img();
    img_t im;
    for (int j = 0; j < NUM_OUTS; j++) im[SEL_W*j +: SEL_W] = 6'(j % NUM_INS);
    return im;
  endfunction

  function automatic img_t rand_legal_img();
    img_t im;
    for (int j = 0; j < NUM_OUTS; j++) im[SEL_W*j +: SEL_W] = 6'($urandom_range(NUM_INS - 1, 0));
    return im;
  endfunction

  function automatic bit img_legal(input img_t im);
    for (int j = 0; j < NUM_OUTS; j++)
      if (int'((im >> (SEL_W * j)) & img_t'(63)) >= NUM_INS) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input img_t im, input int k, input logic [3:0] hi);
    logic [NUM_WORDS*WORD_W-1:0] w;
    w = {hi, im};
    return w[WORD_W*k +: WORD_W];
  endfunction

  task automatic pulse_start();
    cfg.io_cfg_start = 1'b1;
    step();
    cfg.io_cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input int gap);
    int n;
    cfg.io_cfg_valid = 1'b0;
    repeat (gap) step();
    cfg.io_cfg_valid = 1'b1;
    cfg.io_cfg_data  = d;
    n = 0;
    while (cfg.io_cfg_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chki("ready_timeout", n, 0);
    step();
    cfg.io_cfg_valid = 1'b0;
  endtask

  task automatic send_words(input img_t im, input logic [3:0] hi, input int first,
                            input int last, input int maxgap);
    for (int k = first; k <= last; k++)
      send_word(word_of(im, k, hi), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic finish_and_check(input string tag, input img_t im);
    int n = 0;
    int rdy_bad = 0;
    int mux_moved = 0;
    bit legal;
    while (cfg.io_done !== 1'b1 && n < 200) begin
      step();
      n++;
      if (cfg.io_cfg_ready !== 1'b0) rdy_bad++;
      if (cfg.io_done !== 1'b1 && cfg.io_mux_configs !== exp_img) mux_moved++;
    end
    legal = img_legal(im);
    if (legal) begin
      exp_img    = im;
      exp_loaded = 1'b1;
    end
    chki({tag, "_latency"}, n, 56);
    chki({tag, "_error"}, int'(cfg.io_error), legal ? 0 : 1);
    chki({tag, "_loaded"}, int'(cfg.io_cfg_loaded), int'(exp_loaded));
    chk_img({tag, "_image"}, cfg.io_mux_configs, exp_img);
    chki({tag, "_ready_low"}, rdy_bad, 0);
    chki({tag, "_no_glitch"}, mux_moved, 0);
    step();
    chki({tag, "_done_1cyc"}, int'(cfg.io_done), 0);
    chki({tag, "_idle"}, int'(cfg.io_busy), 0);
  endtask

  initial begin
    img_t id_img, bad_img, r_img, ones_img;
    int   done_seen;

    reset_n          = 1'b0;
    cfg.io_cfg_start = 1'b0;
    cfg.io_cfg_valid = 1'b0;
    cfg.io_cfg_data  = '0;
    exp_img          = '0;
    exp_loaded       = 1'b0;
    id_img           = identity_img();
    ones_img         = '1;

    repeat (3) step();
    chk_img("rst_image", cfg.io_mux_configs, '0);
    chki("rst_ready", int'(cfg.io_cfg_ready), 0);
    chki("rst_status", int'({cfg.io_busy, cfg.io_done, cfg.io_error, cfg.io_cfg_loaded}), 0);
    #2 reset_n = 1'b1;
    step();

    // Identity load
    pulse_start();
    chki("busy_in_load", int'(cfg.io_busy), 1);
    send_words(id_img, 4'h0, 0, NUM_WORDS - 1, 0);
    finish_and_check("identity", id_img);
    chki("sel53", int'(cfg.io_mux_configs[CFG_W-1 -: SEL_W]), 14);

    // Illegal last selector: image must be kept bit-for-bit
    bad_img = id_img;
    bad_img[CFG_W-1 -: SEL_W] = 6'd39;
    pulse_start();
    send_words(bad_img, 4'h0, 0, NUM_WORDS - 1, 0);
    finish_and_check("illegal", bad_img);

    // Random legal image under backpressure, then identity with junk in word 40's top bits
    r_img = rand_legal_img();
    pulse_start();
    send_words(r_img, 4'h5, 0, NUM_WORDS - 1, 5);
    finish_and_check("rand_bp", r_img);
    pulse_start();
    send_words(id_img, 4'hF, 0, NUM_WORDS - 1, 5);
    finish_and_check("bp_hibits", id_img);

    // Abort after 20 words, then an all-ones (illegal) load, then a legal restart
    pulse_start();
    send_words(rand_legal_img(), 4'h0, 0, 19, 0);
    pulse_start();
    send_words(ones_img, 4'hF, 0, NUM_WORDS - 1, 0);
    finish_and_check("abort_ones", ones_img);
    r_img = rand_legal_img();
    pulse_start();
    send_words(r_img, 4'h0, 0, NUM_WORDS - 1, 2);
    finish_and_check("restart", r_img);

    // Abort during CHECK after a bad selector was already seen; the restart must commit
    bad_img = rand_legal_img();
    bad_img[SEL_W-1:0] = 6'd63;
    pulse_start();
    send_words(bad_img, 4'h0, 0, NUM_WORDS - 1, 0);
    done_seen = 0;
    repeat (10) begin
      step();
      if (cfg.io_done === 1'b1) done_seen++;
    end
    chki("chk_abort_nodone", done_seen, 0);
    pulse_start();
    send_words(id_img, 4'h0, 0, NUM_WORDS - 1, 0);
    finish_and_check("chk_abort", id_img);

    // Reset about 10 cycles into CHECK
    r_img = rand_legal_img();
    pulse_start();
    send_words(r_img, 4'h0, 0, NUM_WORDS - 1, 0);
    repeat (12) step();
    #2 reset_n = 1'b0;
    #1;
    chk_img("midrst_image", cfg.io_mux_configs, '0);
    chki("midrst_status",
         int'({cfg.io_cfg_ready, cfg.io_busy, cfg.io_done, cfg.io_error, cfg.io_cfg_loaded}), 0);
    exp_img    = '0;
    exp_loaded = 1'b0;
    step();
    #2 reset_n = 1'b1;
    done_seen = 0;
    repeat (70) begin
      step();
      if (cfg.io_done === 1'b1) done_seen++;
    end
    chki("midrst_nodone", done_seen, 0);
    chki("midrst_busy", int'(cfg.io_busy), 0);
    pulse_start();
    send_words(id_img, 4'h0, 0, NUM_WORDS - 1, 1);
    finish_and_check("post_rst", id_img);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
